ps2_cmd_ctrl: RTL and testbench
===============================

Name: ps2_cmd_ctrl

Overview:
- Converts PS/2 set-2 scan bytes from PS2_driver into one-cycle command pulses on the window-control bus (`WIN_CTRL_CMD, 7 bits) and the evolve-control bus (`ENVO_CTRL_CMD, 8 bits).
- Owns the mode level and the visible-cell-count (zoom) register for envolve_sub_top, replacing switch-driven control.
- Also provides typematic auto-repeat for the cursor keys and exports the last make code for the Seg7Device display.

Parameters:
REPEAT_DELAY, 25_000_000, cycles from the first arrow make pulse to the first auto-repeat pulse.
REPEAT_PERIOD, 5_000_000, cycles between subsequent auto-repeat pulses.
PREFIX_TIMEOUT, 1_000_000, cycles without a byte before a pending E0/F0 prefix is discarded.
ZOOM_STEP, 8, visi_cell_num increment/decrement.
ZOOM_MIN, 8, lower saturation and reset value of visi_cell_num.
ZOOM_MAX, 128, upper saturation of visi_cell_num.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
ps2_byte  in  8  received scan byte; valid when ps2_state=1.
ps2_state  in  1  one-cycle strobe: new byte on ps2_byte.
win_ctrl_cmd  out  7  one-hot pulses. Bit 0 M_UP, 1 M_DOWN, 2 M_LEFT, 3 M_RIGHT, 4 Z_IN, 5 Z_OUT, 6 M_MODE.
envo_ctrl_cmd  out  8  one-hot pulses. Bit 0 CLR, 1 INC_V, 2 DEC_V, 3 CUR_USER_DATA, 4 CUR_USER_SET, 5 RANDOM; bits 7:6 are always 0.
mode  out  1  level; toggles on each M_MODE pulse.
visi_cell_num  out  8  zoom register.
last_code  out  8  code byte of the most recent accepted make, excluding prefixes.

Behaviour:
- Reset values: all outputs 0, except visi_cell_num = ZOOM_MIN. Reset also clears the FSM, held-key state and all counters. Reset takes effect mid-sequence; a partially received prefix is lost.
- Parser FSM states: IDLE, E0, F0, E0F0. Transitions occur only on ps2_state.
- IDLE:
  - 0xE0 -> E0.
  - 0xF0 -> F0.
  - 0xAA, 0xFA, 0xEE, 0xFE: ignored, stay IDLE.
  - Any other byte: make(ext=0).
- E0:
  - 0xF0 -> E0F0.
  - 0xE0: stay in E0.
  - Any other byte: make(ext=1) -> IDLE.
- F0: any byte -> break(ext=0) -> IDLE.
- E0F0: any byte -> break(ext=1) -> IDLE.
- Prefix timeout: in a non-IDLE state, PREFIX_TIMEOUT cycles with no strobe -> IDLE, with no event.
- Key map (ext, code):
  - Cursor: (1,75) M_UP, (1,72) M_DOWN, (1,6B) M_LEFT, (1,74) M_RIGHT.
  - Window: (0,55) Z_IN, (0,4E) Z_OUT, (0,3A) M_MODE.
  - Evolve: (0,21) CLR, (0,5B) INC_V, (0,54) DEC_V, (0,29) CUR_USER_DATA, (0,5A) CUR_USER_SET, (0,2D) RANDOM.
  - Unmapped makes update last_code and the held key but produce no pulse.
- Latency: the strobe carrying the final byte at cycle N produces the pulse at cycle N+1.
  - Pulse width is exactly 1 cycle; at most one bit is set across both buses in any cycle.
  - visi_cell_num and mode update in the same cycle N+1.
- Held key: a make records {ext, code} as held.
  - A make equal to the held key (keyboard typematic) is ignored: no pulse, no change to last_code.
  - A make of a different key replaces the held key and pulses normally.
  - A break matching the held key clears the held key; a non-matching break is ignored.
- Auto-repeat: applies only to a held cursor key.
  - The counter starts at the make pulse.
  - First repeat pulse comes REPEAT_DELAY cycles after the make pulse; further pulses every REPEAT_PERIOD cycles.
  - Repeat stops on the cycle after the matching break is decoded.
- Collision: if a repeat pulse and a decoded event fall in the same cycle, the event wins, the repeat pulse is dropped, and the counter restarts.
- Zoom arithmetic (8-bit, saturating, never wraps):
  - Z_IN: visi_cell_num = min(visi_cell_num + ZOOM_STEP, ZOOM_MAX).
  - Z_OUT: visi_cell_num = max(visi_cell_num − ZOOM_STEP, ZOOM_MIN).
  - The Z_IN/Z_OUT pulse is still emitted when the value is saturated.

Test Plan:
- Reset then bytes 21 → envo_ctrl_cmd=0x01 for exactly 1 cycle, one cycle after the strobe; last_code=0x21.
- Bytes E0 75, then E0 75 resent after 1000 cycles, hold 3·REPEAT_PERIOD past REPEAT_DELAY, then E0 F0 75 → 1 make pulse + 4 repeat win_ctrl_cmd=0x01 pulses, none afterwards.
- 20× (55, F0 55) → visi_cell_num steps 8,16,…,128 and stays 128 with 20 Z_IN pulses. Then 20× (4E, F0 4E) → value steps down and ends at 8.
- 3A F0 3A twice → two win_ctrl_cmd=0x40 pulses; mode 0→1→0.
- Byte E0, then idle > PREFIX_TIMEOUT, then 2D → envo_ctrl_cmd=0x20, not treated as extended. Separately, F0 2D alone → no pulse.
- rst asserted between E0 and 72 → no pulse on 72 (0x72 unmapped non-extended); all outputs at reset values.

Source files
------------

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 set-2 scan byte decoder: turns make/break sequences into one-cycle command pulses,
// owns the mode/zoom state and generates typematic auto-repeat for the cursor keys.
module ps2_cmd_ctrl #(
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_PERIOD  = 5_000_000,
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000,
  parameter int unsigned ZOOM_STEP      = 8,
  parameter int unsigned ZOOM_MIN       = 8,
  parameter int unsigned ZOOM_MAX       = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_state,
  output logic [6:0] win_ctrl_cmd,
  output logic [7:0] envo_ctrl_cmd,
  output logic       mode,
  output logic [7:0] visi_cell_num,
  output logic [7:0] last_code
);

  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam int unsigned ToW    = $clog2(PREFIX_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} state_e;

  state_e         state_q, state_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [8:0]     held_q, held_d;
  logic           held_vld_q, held_vld_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_act_q, rep_act_d;
  logic           rep_first_q, rep_first_d;
  logic [6:0]     win_q, win_d;
  logic [5:0]     envo_q, envo_d;
  logic           mode_q, mode_d;
  logic [7:0]     visi_q, visi_d;
  logic [7:0]     last_q, last_d;

  logic           make_ev, brk_ev, ev_ext;
  logic [8:0]     ev_key;
  logic [12:0]    ev_map, held_map;
  logic           dup, mk_acc, brk_acc, rep_fire;
  logic [8:0]     zin_sum;
  logic [7:0]     zin_val, zout_val;

  // Returns {envo[5:0], win[6:0]} for an {ext, code} key.
  function automatic logic [12:0] key_map(input logic [8:0] key);
    logic [12:0] m;
    m = '0;
    case (key)
      9'h175:  m[0]  = 1'b1;
      9'h172:  m[1]  = 1'b1;
      9'h16B:  m[2]  = 1'b1;
      9'h174:  m[3]  = 1'b1;
      9'h055:  m[4]  = 1'b1;
      9'h04E:  m[5]  = 1'b1;
      9'h03A:  m[6]  = 1'b1;
      9'h021:  m[7]  = 1'b1;
      9'h05B:  m[8]  = 1'b1;
      9'h054:  m[9]  = 1'b1;
      9'h029:  m[10] = 1'b1;
      9'h05A:  m[11] = 1'b1;
      9'h02D:  m[12] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Prefix parser
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    make_ev  = 1'b0;
    brk_ev   = 1'b0;
    ev_ext   = 1'b0;
    if (ps2_state) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (ps2_byte == 8'hE0) begin
            state_d = StE0;
          end else if (ps2_byte == 8'hF0) begin
            state_d = StF0;
          end else if (ps2_byte != 8'hAA && ps2_byte != 8'hFA &&
                       ps2_byte != 8'hEE && ps2_byte != 8'hFE) begin
            make_ev = 1'b1;
          end
        end
        StE0: begin
          if (ps2_byte == 8'hF0) begin
            state_d = StE0F0;
          end else if (ps2_byte != 8'hE0) begin
            make_ev = 1'b1;
            ev_ext  = 1'b1;
            state_d = StIdle;
          end
        end
        StF0: begin
          brk_ev  = 1'b1;
          state_d = StIdle;
        end
        StE0F0: begin
          brk_ev  = 1'b1;
          ev_ext  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // A stale prefix is dropped silently after PREFIX_TIMEOUT quiet cycles.
      if (to_cnt_q == ToW'(PREFIX_TIMEOUT - 1)) begin
        state_d  = StIdle;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
    end
  end

  always_comb begin
    ev_key   = {ev_ext, ps2_byte};
    ev_map   = key_map(ev_key);
    held_map = key_map(held_q);
    dup      = held_vld_q && (held_q == ev_key);
    mk_acc   = make_ev && !dup;
    brk_acc  = brk_ev && dup;
    rep_fire = rep_act_q && (rep_cnt_q == (rep_first_q ? RepW'(REPEAT_DELAY - 1)
                                                       : RepW'(REPEAT_PERIOD - 1)));
    zin_sum  = {1'b0, visi_q} + 9'(ZOOM_STEP);
    zin_val  = (zin_sum > 9'(ZOOM_MAX)) ? 8'(ZOOM_MAX) : zin_sum[7:0];
    zout_val = ({1'b0, visi_q} < 9'(ZOOM_MIN + ZOOM_STEP)) ? 8'(ZOOM_MIN)
                                                           : visi_q - 8'(ZOOM_STEP);
  end

  // Event handling; a decoded event always takes priority over a repeat pulse.
  always_comb begin
    win_d       = '0;
    envo_d      = '0;
    mode_d      = mode_q;
    visi_d      = visi_q;
    last_d      = last_q;
    held_d      = held_q;
    held_vld_d  = held_vld_q;
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_act_q ? rep_cnt_q + RepW'(1) : '0;
    if (mk_acc) begin
      held_d      = ev_key;
      held_vld_d  = 1'b1;
      last_d      = ps2_byte;
      win_d       = ev_map[6:0];
      envo_d      = ev_map[12:7];
      rep_act_d   = |ev_map[3:0];
      rep_first_d = 1'b1;
      rep_cnt_d   = '0;
      if (ev_map[6]) mode_d = ~mode_q;
      if (ev_map[4]) visi_d = zin_val;
      if (ev_map[5]) visi_d = zout_val;
    end else if (brk_acc) begin
      held_vld_d = 1'b0;
      rep_act_d  = 1'b0;
      rep_cnt_d  = '0;
    end else if (rep_fire) begin
      win_d       = {3'b000, held_map[3:0]};
      rep_first_d = 1'b0;
      rep_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      to_cnt_q    <= '0;
      held_q      <= '0;
      held_vld_q  <= 1'b0;
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      win_q       <= '0;
      envo_q      <= '0;
      mode_q      <= 1'b0;
      visi_q      <= 8'(ZOOM_MIN);
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      win_q       <= win_d;
      envo_q      <= envo_d;
      mode_q      <= mode_d;
      visi_q      <= visi_d;
      last_q      <= last_d;
    end
  end

  assign win_ctrl_cmd  = win_q;
  assign envo_ctrl_cmd = {2'b00, envo_q};
  assign mode          = mode_q;
  assign visi_cell_num = visi_q;
  assign last_code     = last_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Scoreboard bench for ps2_cmd_ctrl: stimulus queues expected pulses, a negedge monitor
// pops and compares every pulse the DUT emits (value, cycle and side state).
module tb_ps2_cmd_ctrl;

  localparam int D = 2000;
  localparam int P = 500;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic [6:0] win_ctrl_cmd;
  logic [7:0] envo_ctrl_cmd;
  logic       mode;
  logic [7:0] visi_cell_num;
  logic [7:0] last_code;

  ps2_cmd_ctrl #(
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P),
    .PREFIX_TIMEOUT(T),
    .ZOOM_STEP     (8),
    .ZOOM_MIN      (8),
    .ZOOM_MAX      (128)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_byte     (ps2_byte),
    .ps2_state    (ps2_state),
    .win_ctrl_cmd (win_ctrl_cmd),
    .envo_ctrl_cmd(envo_ctrl_cmd),
    .mode         (mode),
    .visi_cell_num(visi_cell_num),
    .last_code    (last_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [6:0] win;
    logic [7:0] envo;
    logic [7:0] visi;
    logic       mode;
    logic [7:0] last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_visi;
  logic m_mode;
  logic [7:0] m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b, output int sc);
    @(posedge clk);
    #1;
    ps2_byte  = b;
    ps2_state = 1'b1;
    sc        = cyc;
    @(posedge clk);
    #1;
    ps2_state = 1'b0;
  endtask

  task automatic push(input int c, input logic [6:0] w, input logic [7:0] e);
    exp_t x;
    x.c = c; x.win = w; x.envo = e; x.visi = 8'(m_visi); x.mode = m_mode; x.last = m_last;
    q.push_back(x);
  endtask

  // Make whose pulse lands one cycle after the strobe; updates the reference model.
  task automatic key(input logic [7:0] b, input logic [6:0] w, input logic [7:0] e);
    int sc;
    send(b, sc);
    if (w == 7'h10) m_visi = (m_visi + 8 > 128) ? 128 : m_visi + 8;
    if (w == 7'h20) m_visi = (m_visi - 8 < 8) ? 8 : m_visi - 8;
    if (w == 7'h40) m_mode = ~m_mode;
    m_last = b;
    push(sc + 1, w, e);
  endtask

  task automatic byte_only(input logic [7:0] b);
    int sc;
    send(b, sc);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && (win_ctrl_cmd != '0 || envo_ctrl_cmd != '0)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: cycle %0d win=0x%0h envo=0x%0h, queue empty",
                 cyc, win_ctrl_cmd, envo_ctrl_cmd);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (x.c != cyc || x.win !== win_ctrl_cmd || x.envo !== envo_ctrl_cmd ||
            x.visi !== visi_cell_num || x.mode !== mode || x.last !== last_code) begin
          n_bad++;
          $display({"FAIL pulse: got cyc=%0d win=%h envo=%h visi=%0d mode=%b last=%h; ",
                    "expected cyc=%0d win=%h envo=%h visi=%0d mode=%b last=%h"},
                   cyc, win_ctrl_cmd, envo_ctrl_cmd, visi_cell_num, mode, last_code,
                   x.c, x.win, x.envo, x.visi, x.mode, x.last);
        end
      end
    end
  end

  initial begin
    int sc;
    int mc;
    rst       = 1'b1;
    ps2_byte  = '0;
    ps2_state = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_visi = 8; m_mode = 1'b0; m_last = 8'h00;
    chk("reset_win", 32'(win_ctrl_cmd), 0);
    chk("reset_envo", 32'(envo_ctrl_cmd), 0);
    chk("reset_mode", 32'(mode), 0);
    chk("reset_visi", 32'(visi_cell_num), 8);
    chk("reset_last", 32'(last_code), 0);

    // CLR
    key(8'h21, 7'h00, 8'h01);

    // Cursor up with typematic resend and auto-repeat
    byte_only(8'hE0);
    key(8'h75, 7'h01, 8'h00);
    mc = q[q.size() - 1].c;
    for (int i = 0; i < 4; i++) push(mc + D + i * P, 7'h01, 8'h00);
    wait_until(mc + 1000);
    byte_only(8'hE0);
    byte_only(8'h75);
    wait_until(mc + D + 3 * P + 100);
    byte_only(8'hE0);
    byte_only(8'hF0);
    byte_only(8'h75);
    repeat (D + P) @(posedge clk);
    #1;

    // Zoom saturation both ways
    for (int i = 0; i < 20; i++) begin
      key(8'h55, 7'h10, 8'h00);
      byte_only(8'hF0);
      byte_only(8'h55);
    end
    for (int i = 0; i < 20; i++) begin
      key(8'h4E, 7'h20, 8'h00);
      byte_only(8'hF0);
      byte_only(8'h4E);
    end
    chk("zoom_floor", 32'(visi_cell_num), 8);

    // Mode toggle twice
    for (int i = 0; i < 2; i++) begin
      key(8'h3A, 7'h40, 8'h00);
      byte_only(8'hF0);
      byte_only(8'h3A);
    end

    // Stale E0 prefix is discarded
    byte_only(8'hE0);
    repeat (T + 50) @(posedge clk);
    key(8'h2D, 7'h00, 8'h20);
    byte_only(8'hF0);
    byte_only(8'h2D);
    byte_only(8'hF0);
    byte_only(8'h2D);
    repeat (5) @(posedge clk);
    #1;
    chk("last_after_breaks", 32'(last_code), 32'h2D);

    // Reset mid-prefix
    key(8'h55, 7'h10, 8'h00);
    key(8'h3A, 7'h40, 8'h00);
    byte_only(8'hE0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_visi = 8; m_mode = 1'b0; m_last = 8'h00;
    chk("rst2_win", 32'(win_ctrl_cmd), 0);
    chk("rst2_envo", 32'(envo_ctrl_cmd), 0);
    chk("rst2_mode", 32'(mode), 0);
    chk("rst2_visi", 32'(visi_cell_num), 8);
    chk("rst2_last", 32'(last_code), 0);
    send(8'h72, sc);
    repeat (5) @(posedge clk);
    #1;
    chk("unmapped_last", 32'(last_code), 32'h72);
    chk("unmapped_visi", 32'(visi_cell_num), 8);

    repeat (10) @(posedge clk);
    #1;
    while (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse: expected win=%h envo=%h at cycle %0d never arrived",
               x.win, x.envo, x.c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
